mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port synchronous SRAM between the core's instruction-fetch port and its data port. It accepts requests on two valid/ready channels, grants at most one per cycle with round-robin priority, drives the SRAM, and routes the one-cycle-later read data back to the correct requester. It sits between the RV32 core (fetch and dmem interfaces) and the unified memory macro. It also provides a fetch-flush hook that discards in-flight fetch responses on control-flow changes.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data SRAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned WORD_OFF = 2;

  localparam int unsigned PORT_IF = 0;
  localparam int unsigned PORT_D  = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit PORT_IF is fetch, bit PORT_D is data.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e last_grant_q;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_IF;
    end else if (|gnt) begin
      last_grant_q <= gnt[PORT_D] ? OWN_D : OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports,
// one access per cycle, and routes read data back one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         if_req_valid,
  output logic                         if_req_ready,
  input  logic [ADDR_W-1:0]            if_req_addr,
  output logic                         if_rsp_valid,
  output logic [DATA_W-1:0]            if_rsp_data,
  input  logic                         if_flush,

  input  logic                         d_req_valid,
  output logic                         d_req_ready,
  input  logic                         d_req_we,
  input  logic [DATA_W/8-1:0]          d_req_be,
  input  logic [ADDR_W-1:0]            d_req_addr,
  input  logic [DATA_W-1:0]            d_req_wdata,
  output logic                         d_rsp_valid,
  output logic [DATA_W-1:0]            d_rsp_data,

  output logic                         mem_en,
  output logic                         mem_we,
  output logic [DATA_W/8-1:0]          mem_be,
  output logic [ADDR_W-WORD_OFF-1:0]   mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned BE_W = be_w(DATA_W);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_if;
  logic       gnt_d;

  owner_e     owner_q;
  owner_e     owner_nxt;
  logic       d_we_q;
  logic       d_we_nxt;

  logic       unused_addr;

  assign unused_addr = ^{if_req_addr[WORD_OFF-1:0], d_req_addr[WORD_OFF-1:0]};

  // A flushed fetch is not eligible, so data may take the slot.
  assign req[PORT_IF] = if_req_valid && !if_flush;
  assign req[PORT_D]  = d_req_valid;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  // Grants are combinational, so they are masked while reset is held.
  assign gnt_if = gnt[PORT_IF] && rst_n;
  assign gnt_d  = gnt[PORT_D]  && rst_n;

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_req_we;
      mem_be    = d_req_be;
      mem_addr  = d_req_addr[ADDR_W-1:WORD_OFF];
      mem_wdata = d_req_wdata;
    end else if (gnt_if) begin
      mem_en    = 1'b1;
      mem_be    = {BE_W{1'b1}};
      mem_addr  = if_req_addr[ADDR_W-1:WORD_OFF];
    end
  end

  // Owner of the access whose read data returns next cycle.
  always_comb begin
    owner_nxt = OWN_NONE;
    d_we_nxt  = 1'b0;
    if (gnt_d) begin
      owner_nxt = OWN_D;
      d_we_nxt  = d_req_we;
    end else if (gnt_if) begin
      owner_nxt = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      d_we_q  <= 1'b0;
    end else begin
      owner_q <= owner_nxt;
      d_we_q  <= d_we_nxt;
    end
  end

  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    d_rsp_valid  = 1'b0;
    d_rsp_data   = '0;
    if (owner_q == OWN_IF && !if_flush) begin
      if_rsp_valid = 1'b1;
      if_rsp_data  = mem_rdata;
    end
    if (owner_q == OWN_D) begin
      d_rsp_valid = 1'b1;
      d_rsp_data  = d_we_q ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port SRAM.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req_valid, if_req_ready, if_rsp_valid, if_flush;
  logic [31:0]       if_req_addr, if_rsp_data;
  logic              d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [3:0]        d_req_be;
  logic [31:0]       d_req_addr, d_req_wdata, d_rsp_data;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [29:0]       mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  logic [31:0] sram [0:255];
  logic        init_done = 1'b0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_flush     (if_flush),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_req_be     (d_req_be),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_data   (d_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word i holds 0xA000_0000 | i, except word 8 which starts at 0x1111_1111.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'hA000_0000 | 32'(i);
      sram[8]   <= 32'h1111_1111;
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    if (if_rsp_valid === 1'b1) begin
      if (if_q.size() == 0) begin
        chk("if_rsp_spurious", 64'(1), 64'(0));
      end else begin
        mon_e = if_q.pop_front();
        chk("if_rsp_data", 64'(if_rsp_data), 64'(mon_e.data));
        chk("if_rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (d_rsp_valid === 1'b1) begin
      if (d_q.size() == 0) begin
        chk("d_rsp_spurious", 64'(1), 64'(0));
      end else begin
        mon_e = d_q.pop_front();
        chk("d_rsp_data", 64'(d_rsp_data), 64'(mon_e.data));
        chk("d_rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = '0;
    d_req_addr = '0; d_req_wdata = '0;
  endtask

  task automatic push_if(input logic [31:0] data);
    if_q.push_back('{data: data, cyc: cyc + 1});
  endtask

  task automatic push_d(input logic [31:0] data);
    d_q.push_back('{data: data, cyc: cyc + 1});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, 64'(if_req_ready), 64'(0));
    chk({tag, "_d_ready"},  64'(d_req_ready),  64'(0));
    chk({tag, "_mem_en"},   64'(mem_en),       64'(0));
    chk({tag, "_mem_we"},   64'(mem_we),       64'(0));
    chk({tag, "_mem_be"},   64'(mem_be),       64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr),     64'(0));
    chk({tag, "_mem_wdata"},64'(mem_wdata),    64'(0));
    chk({tag, "_if_rsp_v"}, 64'(if_rsp_valid), 64'(0));
    chk({tag, "_d_rsp_v"},  64'(d_rsp_valid),  64'(0));
    chk({tag, "_if_rsp_d"}, 64'(if_rsp_data),  64'(0));
    chk({tag, "_d_rsp_d"},  64'(d_rsp_data),   64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Requests present during reset must not be granted.
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid  = 1'b1; d_req_addr  = 32'h18;
    #2;
    chk_all_zero("reset");
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single fetch at 0x10 -> word 4.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    push_if(32'hA000_0004);
    #2;
    chk("f1_if_ready", 64'(if_req_ready), 64'(1));
    chk("f1_d_ready",  64'(d_req_ready),  64'(0));
    chk("f1_mem_en",   64'(mem_en),       64'(1));
    chk("f1_mem_we",   64'(mem_we),       64'(0));
    chk("f1_mem_be",   64'(mem_be),       64'(4'hF));
    chk("f1_mem_addr", 64'(mem_addr),     64'(30'h4));
    step();
    idle();
    #2;
    chk("f1_idle_if_ready", 64'(if_req_ready), 64'(0));
    chk("f1_idle_d_ready",  64'(d_req_ready),  64'(0));
    chk("f1_idle_mem_en",   64'(mem_en),       64'(0));

    // Continuous dual request: D, IF, D, IF, D, IF.
    for (int k = 0; k < 6; k++) begin
      step();
      if_req_valid = 1'b1; if_req_addr = 32'h14;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_be = 4'hF; d_req_addr = 32'h18;
      if (k % 2 == 0) push_d(32'hA000_0006);
      else            push_if(32'hA000_0005);
      #2;
      chk("dual_if_ready", 64'(if_req_ready), 64'(k % 2));
      chk("dual_d_ready",  64'(d_req_ready),  64'((k + 1) % 2));
      chk("dual_mem_addr", 64'(mem_addr),     (k % 2 == 0) ? 64'(6) : 64'(5));
    end
    step();
    idle();

    // Partial store then load of word 8 (initially 0x1111_1111).
    step();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'b0011;
    d_req_addr = 32'h20; d_req_wdata = 32'hDEAD_BEEF;
    push_d(32'h0);
    #2;
    chk("st_d_ready",   64'(d_req_ready), 64'(1));
    chk("st_mem_we",    64'(mem_we),      64'(1));
    chk("st_mem_be",    64'(mem_be),      64'(4'b0011));
    chk("st_mem_addr",  64'(mem_addr),    64'(8));
    chk("st_mem_wdata", 64'(mem_wdata),   64'(32'hDEAD_BEEF));
    step();
    d_req_we = 1'b0; d_req_be = 4'hF; d_req_wdata = '0;
    push_d(32'h1111_BEEF);
    #2;
    chk("ld_d_ready",  64'(d_req_ready), 64'(1));
    chk("ld_mem_we",   64'(mem_we),      64'(0));
    chk("ld_mem_addr", 64'(mem_addr),    64'(8));
    step();
    idle();

    // Fetch granted, then flushed in its response cycle.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #2;
    chk("fl_if_ready", 64'(if_req_ready), 64'(1));
    step();
    idle();
    if_flush = 1'b1;
    #2;
    chk("fl_if_rsp_valid", 64'(if_rsp_valid), 64'(0));
    chk("fl_if_rsp_data",  64'(if_rsp_data),  64'(0));
    step();
    if_flush = 1'b0;
    d_req_valid = 1'b1; d_req_be = 4'hF; d_req_addr = 32'h0;
    push_d(32'hA000_0000);
    #2;
    chk("fl_pre_d_ready", 64'(d_req_ready), 64'(1));
    // Data won last, so only the flush keeps fetch from this tie.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h14; if_flush = 1'b1;
    d_req_addr = 32'h18;
    push_d(32'hA000_0006);
    #2;
    chk("fl_tie_if_ready", 64'(if_req_ready), 64'(0));
    chk("fl_tie_d_ready",  64'(d_req_ready),  64'(1));
    step();
    if_flush = 1'b0;
    push_if(32'hA000_0005);
    #2;
    chk("fl_after_if_ready", 64'(if_req_ready), 64'(1));
    chk("fl_after_d_ready",  64'(d_req_ready),  64'(0));
    step();
    idle();

    // Reset in the response cycle of a load drops the response.
    step();
    d_req_valid = 1'b1; d_req_be = 4'hF; d_req_addr = 32'h1C;
    #2;
    chk("rm_d_ready", 64'(d_req_ready), 64'(1));
    step();
    idle();
    rst_n = 1'b0;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #2;
    chk_all_zero("rst_mid");
    idle();
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h14;
    d_req_valid = 1'b1; d_req_be = 4'hF; d_req_addr = 32'h18;
    push_d(32'hA000_0006);
    #2;
    chk("post_rst_if_ready", 64'(if_req_ready), 64'(0));
    chk("post_rst_d_ready",  64'(d_req_ready),  64'(1));
    step();
    push_if(32'hA000_0005);
    #2;
    chk("post_rst2_if_ready", 64'(if_req_ready), 64'(1));
    step();
    idle();
    repeat (3) step();

    chk("if_q_drained", 64'(if_q.size()), 64'(0));
    chk("d_q_drained",  64'(d_q.size()),  64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
